// File: rtl/liteeth_sram_fifo_ctrl.sv
// Ring-buffer FIFO controller around a 1RW+1R SRAM macro (rw0 write-only, r0 read).
// A 2-entry output buffer absorbs the macro's 1-cycle read latency for full throughput.
module liteeth_sram_fifo_ctrl #(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  sram_rw0_ce,
    output logic                  sram_rw0_we,
    output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
    output logic [BITS-1:0]       sram_rw0_wd,
    output logic                  sram_r0_ce,
    output logic [ADDR_WIDTH-1:0] sram_r0_addr,
    input  logic [BITS-1:0]       sram_r0_rd
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_P = (ADDR_WIDTH+1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH+1:0] LVL_ONE = (ADDR_WIDTH+2)'(1);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_inflight;
    logic [1:0]            r_obuf_cnt;
    logic [BITS-1:0]       r_obuf0;
    logic [BITS-1:0]       r_obuf1;
    logic [ADDR_WIDTH+1:0] r_level;

    logic [ADDR_WIDTH:0]   w_sram_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_cap;
    logic                  w_rd;
    logic [2:0]            w_pend;
    logic [1:0]            w_obuf_left;

    // Pointers carry one extra wrap bit so full (cnt == depth) and empty differ.
    assign w_sram_cnt  = r_wr_ptr - r_rd_ptr;
    assign in_ready    = (w_sram_cnt != DEPTH_P) && !flush;
    // rst_n gating keeps the macro write port idle while reset is held.
    assign w_push      = in_valid && in_ready && rst_n;
    assign out_valid   = (r_obuf_cnt != 2'd0);
    assign out_data    = r_obuf0;
    assign w_pop       = out_valid && out_ready && !flush;
    assign w_cap       = r_inflight && !flush;
    assign w_pend      = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd        = !flush && (w_sram_cnt != '0) && (w_pend < 3'd2);
    assign w_obuf_left = r_obuf_cnt - {1'b0, w_pop};

    assign sram_rw0_ce   = w_push;
    assign sram_rw0_we   = w_push;
    assign sram_rw0_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign sram_rw0_wd   = w_push ? in_data : '0;
    assign sram_r0_ce    = w_rd;
    assign sram_r0_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
    assign level         = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
            r_obuf0    <= '0;
            r_obuf1    <= '0;
            r_level    <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
            r_level    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_inflight <= w_rd;
            r_obuf_cnt <= r_obuf_cnt + {1'b0, w_cap} - {1'b0, w_pop};
            // Pop shifts the tail forward; a same-cycle capture lands behind what remains.
            if (w_pop) r_obuf0 <= r_obuf1;
            if (w_cap) begin
                if (w_obuf_left == 2'd0) r_obuf0 <= sram_r0_rd;
                else                     r_obuf1 <= sram_r0_rd;
            end
            // Read issue and capture only move words between stages; level tracks ends.
            if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
            else if (!w_push && w_pop) r_level <= r_level - LVL_ONE;
        end
    end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Directed bench for liteeth_sram_fifo_ctrl with a behavioural 1RW+1R macro model
// and a queue scoreboard for stream ordering.
module tb_liteeth_sram_fifo_ctrl;

    localparam int BITS  = 64;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] out_data;
    logic [AW+1:0]   level;
    logic            sram_rw0_ce, sram_rw0_we, sram_r0_ce;
    logic [AW-1:0]   sram_rw0_addr, sram_r0_addr;
    logic [BITS-1:0] sram_rw0_wd, sram_r0_rd;

    liteeth_sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .sram_rw0_ce(sram_rw0_ce), .sram_rw0_we(sram_rw0_we),
        .sram_rw0_addr(sram_rw0_addr), .sram_rw0_wd(sram_rw0_wd),
        .sram_r0_ce(sram_r0_ce), .sram_r0_addr(sram_r0_addr), .sram_r0_rd(sram_r0_rd)
    );

    always #5 clk = ~clk;

    // Macro model: read data valid only in the cycle after the r0 sample edge.
    logic [BITS-1:0] mem [0:DEPTH-1];
    logic [BITS-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (sram_rw0_ce && sram_rw0_we) mem[sram_rw0_addr] <= sram_rw0_wd;
        rd_q <= sram_r0_ce ? mem[sram_r0_addr] : 64'hDEAD_BEEF_0BAD_F00D;
    end
    assign sram_r0_rd = rd_q;

    int n_cmp = 0;
    int n_err = 0;
    int mon_err = 0;
    int n_acc = 0;
    logic [BITS-1:0] exp_q [$];

    logic            s_ir, s_wce, s_we, s_rce, s_ov;
    logic [AW-1:0]   s_waddr, s_raddr;
    logic [BITS-1:0] s_od;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample just after, return 1 time unit past the edge.
    task automatic cyc(input logic v, input logic [63:0] d, input logic r, input logic f);
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; flush = f;
        #2;
        s_ir = in_ready; s_wce = sram_rw0_ce; s_we = sram_rw0_we; s_waddr = sram_rw0_addr;
        s_rce = sram_r0_ce; s_raddr = sram_r0_addr; s_ov = out_valid; s_od = out_data;
        if (sram_rw0_we && !sram_rw0_ce) mon_err++;
        if (sram_rw0_ce != (v && in_ready)) mon_err++;
        if (level > 12'(DEPTH + 2)) mon_err++;
        if (v && in_ready) begin
            exp_q.push_back(d);
            n_acc++;
        end
        if (out_valid && r && !f) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
            else                   chk("data", out_data, exp_q.pop_front());
        end
        if (f) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_ov", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Reset state
        #12;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wce", 64'(sram_rw0_ce | sram_rw0_we), 64'd0);
        chk("rst_rce", 64'(sram_r0_ce), 64'd0);
        chk("rst_addr", 64'({sram_rw0_addr, sram_r0_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word: write cycle 0, read issue cycle 1, visible after the third edge
        cyc(1'b1, 64'hA5, 1'b1, 1'b0);
        chk("w1_we", 64'(s_we), 64'd1);
        chk("w1_waddr", 64'(s_waddr), 64'd0);
        chk("w1_level", 64'(level), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("w1_rce", 64'(s_rce), 64'd1);
        chk("w1_raddr", 64'(s_raddr), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("w1_ov_early", 64'(s_ov), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("w1_ov", 64'(s_ov), 64'd1);
        chk("w1_od", s_od, 64'hA5);
        chk("w1_level_end", 64'(level), 64'd0);

        // Fill: 1024 in SRAM plus 2 prefetched into the output buffer
        n_acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 64'(i), 1'b0, 1'b0);
        chk("full_acc", 64'(n_acc), 64'd1026);
        chk("full_level", 64'(level), 64'd1026);
        chk("full_ir", 64'(in_ready), 64'd0);
        repeat (3) cyc(1'b1, 64'hFFFF, 1'b0, 1'b0);
        chk("full_blocked", 64'(n_acc), 64'd1026);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("full_first_rd", 64'(s_rce), 64'd1);
        chk("full_ir_reopen", 64'(in_ready), 64'd1);
        drain(1100);
        chk("full_level_end", 64'(level), 64'd0);

        // Steady state: fill takes two edges, then one word per cycle with 3 held
        // (one in SRAM, one in flight, one at the output head).
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
            if (i >= 3) chk("ss_ov", 64'(s_ov), 64'd1);
            if (i >= 2) chk("ss_level", 64'(level), 64'd3);
        end
        drain(10);

        // Random stream: 5000 words, pointers wrap past 1023 and 2047
        n_acc = 0;
        cnt = 0;
        while ((n_acc < 5000 || exp_q.size() != 0) && cnt < 40000) begin
            cyc((n_acc < 5000) && ($urandom_range(0, 3) != 0),
                {32'hC0DE_0000, 32'(n_acc)}, 1'($urandom_range(0, 1)), 1'b0);
            cnt++;
        end
        chk("rand_acc", 64'(n_acc), 64'd5000);
        chk("rand_left", 64'(exp_q.size()), 64'd0);
        chk("rand_level", 64'(level), 64'd0);

        // Flush with a read in flight: stale data must not surface
        cyc(1'b1, 64'h10, 1'b0, 1'b0);
        cyc(1'b1, 64'h11, 1'b0, 1'b0);
        cyc(1'b1, 64'h12, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("fl_level", 64'(level), 64'd3);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fl_rd_issue", 64'(s_rce), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("fl_ir", 64'(s_ir), 64'd0);
        chk("fl_ov", 64'(out_valid), 64'd0);
        chk("fl_level_zero", 64'(level), 64'd0);
        cyc(1'b1, 64'h77, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fl_ov_stale", 64'(s_ov), 64'd0);
        drain(10);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ov", 64'(out_valid), 64'd0);
        chk("ar_level", 64'(level), 64'd0);
        chk("ar_ir", 64'(in_ready), 64'd1);
        chk("ar_wce", 64'(sram_rw0_ce | sram_rw0_we), 64'd0);
        chk("ar_rce", 64'(sram_r0_ce), 64'd0);
        chk("ar_addr", 64'({sram_rw0_addr, sram_r0_addr}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
        drain(20);

        chk("monitor", 64'(mon_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
